// File: rtl/bcu_pkg.sv
// bcu_pkg: shared types and field layout for the branch conditional unit.
package bcu_pkg;

  // Resolution FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_CR = 2'd1,
    ST_RESOLVE = 2'd2
  } bcu_state_e;

  // Field positions inside the 28-bit instruction body.
  // BO bit 0 (architectural numbering) is the most significant bit of the BO field.
  localparam int BO_LSB = 0;
  localparam int BO_MSB = 4;
  localparam int BI_LSB = 5;
  localparam int BI_MSB = 9;
  localparam int BD_LSB = 10;
  localparam int BD_MSB = 25;
  localparam int AA_POS = 26;
  localparam int LK_POS = 27;

  // Functional unit identifier reported to the rest of the core.
  localparam int BranchUnitID = 6;

  // BD is a word displacement: append 2'b00 and sign extend to 64 bits.
  function automatic logic [63:0] sext_bd(input logic [15:0] bd);
    return {{46{bd[15]}}, bd, 2'b00};
  endfunction

endpackage

// File: rtl/bcu_target_calc.sv
// bcu_target_calc: combinational branch target and fall-through address.
module bcu_target_calc
  import bcu_pkg::*;
(
  input  logic [15:0] bd_i,
  input  logic        aa_i,
  input  logic [63:0] address_i,
  input  logic        is64_i,
  output logic [63:0] target_o,
  output logic [63:0] seq_o
);

  logic [63:0] disp;
  logic [63:0] raw_target;
  logic [63:0] raw_seq;
  logic [63:0] mask;

  // Absolute or relative target, next sequential address, both clipped in 32-bit mode.
  always_comb begin
    disp       = sext_bd(bd_i);
    raw_target = aa_i ? disp : (address_i + disp);
    raw_seq    = address_i + 64'd4;
    mask       = is64_i ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    target_o   = raw_target & mask;
    seq_o      = raw_seq & mask;
  end

endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: resolves B-form conditional branches and owns CTR and LR.
// Optional feature macro BCU_STATS_EN adds saturating taken/not-taken counters.
module branch_cond_unit
  import bcu_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        stall_i,
  input  logic [27:0] instructionBody_i,
  input  logic [63:0] instructionAddress_i,
  input  logic [63:0] instMajId_i,
  input  logic        is64Bit_i,
  input  logic        crValid_i,
  input  logic [31:0] crBits_i,
  input  logic        sprWrEn_i,
  input  logic        sprSel_i,
  input  logic [63:0] sprData_i,
  output logic        busy_o,
  output logic        enable_o,
  output logic        taken_o,
  output logic [63:0] redirectAddr_o,
  output logic [63:0] instMajId_o,
`ifdef BCU_STATS_EN
  output logic [31:0] takenCount_o,
  output logic [31:0] notTakenCount_o,
`endif
  output logic [63:0] ctr_o,
  output logic [63:0] lr_o
);

  bcu_state_e  state_q, state_d;
  logic [4:0]  bo_q, bo_d;
  logic [4:0]  bi_q, bi_d;
  logic [15:0] bd_q, bd_d;
  logic        aa_q, aa_d;
  logic        lk_q, lk_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] id_q, id_d;
  logic        is64_q, is64_d;
  logic        crbit_q, crbit_d;
  logic [63:0] ctr_q, ctr_d;
  logic [63:0] lr_q, lr_d;
  logic        enable_q, enable_d;
  logic        taken_q, taken_d;
  logic [63:0] redirect_q, redirect_d;
  logic [63:0] out_id_q, out_id_d;

  logic [63:0] target;
  logic [63:0] seq_addr;
  logic [63:0] ctr_m;
  logic        ctr_nz;
  logic        ctr_ok;
  logic        cond_ok;
  logic        taken;
  logic        resolve_fire;
  logic        unused_hint;

  // BO bit 4 is a static prediction hint and has no effect on resolution.
  assign unused_hint = bo_q[0];

  bcu_target_calc u_target (
    .bd_i      (bd_q),
    .aa_i      (aa_q),
    .address_i (addr_q),
    .is64_i    (is64_q),
    .target_o  (target),
    .seq_o     (seq_addr)
  );

  // Branch condition evaluation from the captured body, latched CR bit and current CTR.
  always_comb begin
    ctr_m        = bo_q[2] ? ctr_q : (ctr_q - 64'd1);
    ctr_nz       = is64_q ? (ctr_m != 64'd0) : (ctr_m[31:0] != 32'd0);
    ctr_ok       = bo_q[2] | (ctr_nz ^ bo_q[1]);
    cond_ok      = bo_q[4] | (crbit_q == bo_q[3]);
    taken        = ctr_ok & cond_ok;
    resolve_fire = (state_q == ST_RESOLVE) && !stall_i;
  end

  // Next-state and datapath: SPR writes first so a branch update to the same register wins.
  always_comb begin
    state_d    = state_q;
    bo_d       = bo_q;
    bi_d       = bi_q;
    bd_d       = bd_q;
    aa_d       = aa_q;
    lk_d       = lk_q;
    addr_d     = addr_q;
    id_d       = id_q;
    is64_d     = is64_q;
    crbit_d    = crbit_q;
    ctr_d      = ctr_q;
    lr_d       = lr_q;
    enable_d   = 1'b0;
    taken_d    = taken_q;
    redirect_d = redirect_q;
    out_id_d   = out_id_q;
    if (!stall_i) begin
      if (sprWrEn_i && !sprSel_i) ctr_d = sprData_i;
      if (sprWrEn_i && sprSel_i)  lr_d  = sprData_i;
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            bo_d    = instructionBody_i[BO_MSB:BO_LSB];
            bi_d    = instructionBody_i[BI_MSB:BI_LSB];
            bd_d    = instructionBody_i[BD_MSB:BD_LSB];
            aa_d    = instructionBody_i[AA_POS];
            lk_d    = instructionBody_i[LK_POS];
            addr_d  = instructionAddress_i;
            id_d    = instMajId_i;
            is64_d  = is64Bit_i;
            crbit_d = crBits_i[instructionBody_i[BI_MSB:BI_LSB]];
            state_d = (instructionBody_i[BO_MSB] || crValid_i) ? ST_RESOLVE : ST_WAIT_CR;
          end
        end
        ST_WAIT_CR: begin
          if (crValid_i) begin
            crbit_d = crBits_i[bi_q];
            state_d = ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          enable_d   = 1'b1;
          taken_d    = taken;
          redirect_d = taken ? target : seq_addr;
          out_id_d   = id_q;
          if (!bo_q[2]) ctr_d = ctr_m;
          if (lk_q)     lr_d  = seq_addr;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and architectural registers; reset discards any in-flight branch.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      bo_q       <= '0;
      bi_q       <= '0;
      bd_q       <= '0;
      aa_q       <= 1'b0;
      lk_q       <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      is64_q     <= 1'b0;
      crbit_q    <= 1'b0;
      ctr_q      <= '0;
      lr_q       <= '0;
      enable_q   <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= '0;
      out_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      bo_q       <= bo_d;
      bi_q       <= bi_d;
      bd_q       <= bd_d;
      aa_q       <= aa_d;
      lk_q       <= lk_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      is64_q     <= is64_d;
      crbit_q    <= crbit_d;
      ctr_q      <= ctr_d;
      lr_q       <= lr_d;
      enable_q   <= enable_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      out_id_q   <= out_id_d;
    end
  end

  assign busy_o         = (state_q != ST_IDLE) || stall_i;
  assign enable_o       = enable_q;
  assign taken_o        = taken_q;
  assign redirectAddr_o = redirect_q;
  assign instMajId_o    = out_id_q;
  assign ctr_o          = ctr_q;
  assign lr_o           = lr_q;

`ifdef BCU_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] not_taken_cnt_q, not_taken_cnt_d;

  // Saturating outcome counters, bumped on every resolved branch.
  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (resolve_fire) begin
      if (taken && (taken_cnt_q != 32'hFFFF_FFFF))
        taken_cnt_d = taken_cnt_q + 32'd1;
      if (!taken && (not_taken_cnt_q != 32'hFFFF_FFFF))
        not_taken_cnt_d = not_taken_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign takenCount_o    = taken_cnt_q;
  assign notTakenCount_o = not_taken_cnt_q;
`else
  logic unused_fire;
  assign unused_fire = resolve_fire;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: table-driven bench with a scoreboard for branch_cond_unit.
module tb_branch_cond_unit;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        stall_i;
  logic [27:0] instructionBody_i;
  logic [63:0] instructionAddress_i;
  logic [63:0] instMajId_i;
  logic        is64Bit_i;
  logic        crValid_i;
  logic [31:0] crBits_i;
  logic        sprWrEn_i;
  logic        sprSel_i;
  logic [63:0] sprData_i;
  logic        busy_o;
  logic        enable_o;
  logic        taken_o;
  logic [63:0] redirectAddr_o;
  logic [63:0] instMajId_o;
  logic [63:0] ctr_o;
  logic [63:0] lr_o;
`ifdef BCU_STATS_EN
  logic [31:0] takenCount_o;
  logic [31:0] notTakenCount_o;
`endif

  branch_cond_unit dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .enable_i             (enable_i),
    .stall_i              (stall_i),
    .instructionBody_i    (instructionBody_i),
    .instructionAddress_i (instructionAddress_i),
    .instMajId_i          (instMajId_i),
    .is64Bit_i            (is64Bit_i),
    .crValid_i            (crValid_i),
    .crBits_i             (crBits_i),
    .sprWrEn_i            (sprWrEn_i),
    .sprSel_i             (sprSel_i),
    .sprData_i            (sprData_i),
    .busy_o               (busy_o),
    .enable_o             (enable_o),
    .taken_o              (taken_o),
    .redirectAddr_o       (redirectAddr_o),
    .instMajId_o          (instMajId_o),
`ifdef BCU_STATS_EN
    .takenCount_o         (takenCount_o),
    .notTakenCount_o      (notTakenCount_o),
`endif
    .ctr_o                (ctr_o),
    .lr_o                 (lr_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [15:0] bd;
    logic        aa;
    logic        lk;
    logic [63:0] addr;
    logic        is64;
    logic [31:0] cr;
    logic [63:0] ctr_init;
    logic [63:0] lr_init;
    int          waits;
    logic        spr_en;
    logic        spr_sel;
    logic [63:0] spr_data;
    logic        exp_taken;
    logic [63:0] exp_redirect;
    logic [63:0] exp_ctr;
    logic [63:0] exp_lr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [63:0] redirect;
    logic [63:0] id;
    logic [63:0] ctr;
    logic [63:0] lr;
    int          latency;
    int          accept_cycle;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cycle_count = 0;
  logic [63:0] last_redirect = '0;
  vec_t        vecs[15];

  always @(posedge clock_i) cycle_count++;

  function automatic vec_t mk(
    input logic [4:0] bo, input logic [4:0] bi, input logic [15:0] bd, input logic aa,
    input logic lk, input logic [63:0] addr, input logic is64, input logic [31:0] cr,
    input logic [63:0] ctr_init, input logic [63:0] lr_init, input int waits,
    input logic spr_en, input logic spr_sel, input logic [63:0] spr_data,
    input logic exp_taken, input logic [63:0] exp_redirect, input logic [63:0] exp_ctr,
    input logic [63:0] exp_lr, input int exp_lat);
    vec_t v;
    v.bo = bo; v.bi = bi; v.bd = bd; v.aa = aa; v.lk = lk; v.addr = addr; v.is64 = is64;
    v.cr = cr; v.ctr_init = ctr_init; v.lr_init = lr_init; v.waits = waits;
    v.spr_en = spr_en; v.spr_sel = spr_sel; v.spr_data = spr_data;
    v.exp_taken = exp_taken; v.exp_redirect = exp_redirect; v.exp_ctr = exp_ctr;
    v.exp_lr = exp_lr; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every enable_o pulse must match the oldest pending branch.
  always @(negedge clock_i) begin
    if (!reset_i && enable_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_enable actual=1 expected=0 at cycle %0d", cycle_count);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("taken", {63'd0, taken_o}, {63'd0, mon_e.taken});
        checkOutput("redirect", redirectAddr_o, mon_e.redirect);
        checkOutput("inst_maj_id", instMajId_o, mon_e.id);
        checkOutput("ctr", ctr_o, mon_e.ctr);
        checkOutput("lr", lr_o, mon_e.lr);
        checkOutput("latency", 64'(cycle_count - mon_e.accept_cycle), 64'(mon_e.latency));
      end
    end
  end

  task automatic spr_write(input logic sel, input logic [63:0] data);
    sprWrEn_i = 1'b1;
    sprSel_i  = sel;
    sprData_i = data;
    @(posedge clock_i); #1;
    sprWrEn_i = 1'b0;
  endtask

  task automatic drive_accept(input vec_t v, input logic [63:0] id, input bit push);
    exp_t e;
    spr_write(1'b0, v.ctr_init);
    spr_write(1'b1, v.lr_init);
    instructionBody_i    = {v.lk, v.aa, v.bd, v.bi, v.bo};
    instructionAddress_i = v.addr;
    instMajId_i          = id;
    is64Bit_i            = v.is64;
    crValid_i            = (v.waits == 0);
    crBits_i             = (v.waits == 0) ? v.cr : ~v.cr;
    enable_i             = 1'b1;
    @(posedge clock_i); #1;
    enable_i = 1'b0;
    checkOutput("accept_busy", {63'd0, busy_o}, 64'd1);
    if (push) begin
      e.taken        = v.exp_taken;
      e.redirect     = v.exp_redirect;
      e.id           = id;
      e.ctr          = v.exp_ctr;
      e.lr           = v.exp_lr;
      e.latency      = v.exp_lat;
      e.accept_cycle = cycle_count;
      sb_q.push_back(e);
      last_redirect  = v.exp_redirect;
    end
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock_i); #1;
      sprWrEn_i = 1'b0;
      @(negedge clock_i); #1;
      if (sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout pending=%0d expected=0", sb_q.size());
      sb_q.delete();
    end else begin
      checkOutput("idle_busy", {63'd0, busy_o}, 64'd0);
    end
    @(posedge clock_i); #1;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [63:0] id);
    drive_accept(v, id, 1'b1);
    if (v.spr_en) begin
      sprWrEn_i = 1'b1;
      sprSel_i  = v.spr_sel;
      sprData_i = v.spr_data;
    end
    if (v.waits > 0) begin
      repeat (v.waits - 1) begin
        @(posedge clock_i); #1;
        sprWrEn_i = 1'b0;
        if (v.exp_lat > 1) checkOutput("wait_busy", {63'd0, busy_o}, 64'd1);
      end
      crValid_i = 1'b1;
      crBits_i  = v.cr;
    end
    wait_done();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        v;
    logic [63:0] prev_redirect;

    //            bo        bi  bd         aa lk addr                    64 cr             ctr_init              lr_init  w  spr sel data       taken redirect                ctr                     lr        lat
    vecs[0]  = mk(5'b10100, 0,  16'd2,     0, 0, 64'h1000,               1, 32'h0,         64'd5,                64'd0,   0, 0, 0, 64'h0,     1, 64'h1008,               64'd5,                  64'd0,    1);
    vecs[1]  = mk(5'b00010, 3,  16'h0010,  0, 0, 64'h3000,               1, 32'h0,         64'd1,                64'd0,   0, 0, 0, 64'h0,     1, 64'h3040,               64'd0,                  64'd0,    1);
    vecs[2]  = mk(5'b00010, 3,  16'h0010,  0, 0, 64'h3000,               1, 32'h0,         64'd0,                64'd0,   0, 0, 0, 64'h0,     0, 64'h3004,               64'hFFFF_FFFF_FFFF_FFFF, 64'd0,   1);
    vecs[3]  = mk(5'b01100, 2,  16'hFFFE,  0, 0, 64'h4000,               1, 32'h4,         64'd7,                64'd0,   3, 0, 0, 64'h0,     1, 64'h3FF8,               64'd7,                  64'd0,    4);
    vecs[4]  = mk(5'b10100, 0,  16'd2,     0, 0, 64'hFFFF_FFFC,          0, 32'h0,         64'd9,                64'd0,   0, 0, 0, 64'h0,     1, 64'h4,                  64'd9,                  64'd0,    1);
    vecs[5]  = mk(5'b10100, 0,  16'hFFFF,  1, 0, 64'h1234_5678_0000_1000, 0, 32'h0,        64'd9,                64'd0,   0, 0, 0, 64'h0,     1, 64'hFFFF_FFFC,          64'd9,                  64'd0,    1);
    vecs[6]  = mk(5'b00100, 5,  16'd8,     0, 1, 64'h2000,               1, 32'h20,        64'd3,                64'd0,   0, 0, 0, 64'h0,     0, 64'h2004,               64'd3,                  64'h2004, 1);
    vecs[7]  = mk(5'b10000, 0,  16'd2,     0, 0, 64'h500,                0, 32'h0,         64'h1_0000_0001,      64'd0,   0, 0, 0, 64'h0,     0, 64'h504,                64'h1_0000_0000,        64'd0,    1);
    vecs[8]  = mk(5'b10000, 0,  16'h0100,  0, 0, 64'h8000,               1, 32'h0,         64'd2,                64'd0,   0, 0, 0, 64'h0,     1, 64'h8400,               64'd1,                  64'd0,    1);
    vecs[9]  = mk(5'b00100, 31, 16'd4,     0, 1, 64'h9000,               1, 32'h7FFF_FFFF, 64'd4,                64'd0,   1, 0, 0, 64'h0,     1, 64'h9010,               64'd4,                  64'h9004, 2);
    vecs[10] = mk(5'b00100, 5,  16'd8,     0, 1, 64'h2000,               1, 32'h20,        64'h11,               64'd0,   0, 1, 1, 64'hDEAD,  0, 64'h2004,               64'h11,                 64'h2004, 1);
    vecs[11] = mk(5'b00100, 5,  16'd8,     0, 1, 64'h2000,               1, 32'h20,        64'h11,               64'd0,   0, 1, 0, 64'hABCD,  0, 64'h2004,               64'hABCD,               64'h2004, 1);
    vecs[12] = mk(5'b10000, 0,  16'd2,     0, 0, 64'h2000,               1, 32'h0,         64'd2,                64'h33,  0, 1, 0, 64'h77,    1, 64'h2008,               64'd1,                  64'h33,   1);
    vecs[13] = mk(5'b10100, 0,  16'd2,     0, 0, 64'h2000,               1, 32'h0,         64'd6,                64'h33,  0, 1, 1, 64'h99,    1, 64'h2008,               64'd6,                  64'h99,   1);
    vecs[14] = mk(5'b10100, 0,  16'd2,     0, 0, 64'h6000,               1, 32'h0,         64'd8,                64'd0,   2, 0, 0, 64'h0,     1, 64'h6008,               64'd8,                  64'd0,    1);

    reset_i              = 1'b1;
    enable_i             = 1'b0;
    stall_i              = 1'b0;
    instructionBody_i    = '0;
    instructionAddress_i = '0;
    instMajId_i          = '0;
    is64Bit_i            = 1'b1;
    crValid_i            = 1'b0;
    crBits_i             = '0;
    sprWrEn_i            = 1'b0;
    sprSel_i             = 1'b0;
    sprData_i            = '0;

    #3;
    checkOutput("reset_enable", {63'd0, enable_o}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("reset_ctr", ctr_o, 64'd0);
    checkOutput("reset_lr", lr_o, 64'd0);
    checkOutput("reset_redirect", redirectAddr_o, 64'd0);
    #10;
    reset_i = 1'b0;
    @(posedge clock_i); #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], 64'hA000 + 64'(i));
    end

    prev_redirect = last_redirect;
    v = mk(5'b10100, 0, 16'd4, 0, 0, 64'hA000, 1, 32'h0, 64'h21, 64'h22, 0, 0, 0, 64'h0,
           1, 64'hA010, 64'h21, 64'h22, 3);
    drive_accept(v, 64'hB00, 1'b1);
    stall_i   = 1'b1;
    sprWrEn_i = 1'b1;
    sprSel_i  = 1'b0;
    sprData_i = 64'hBAD;
    repeat (2) begin
      @(posedge clock_i);
      @(negedge clock_i);
      checkOutput("stall_enable", {63'd0, enable_o}, 64'd0);
      checkOutput("stall_busy", {63'd0, busy_o}, 64'd1);
      checkOutput("stall_redirect_hold", redirectAddr_o, prev_redirect);
      checkOutput("stall_ctr_hold", ctr_o, 64'h21);
    end
    stall_i   = 1'b0;
    sprWrEn_i = 1'b0;
    wait_done();

    v = mk(5'b01100, 2, 16'd4, 0, 0, 64'hC000, 1, 32'h4, 64'h55, 64'h66, 1, 0, 0, 64'h0,
           1, 64'hC010, 64'h55, 64'h66, 2);
    drive_accept(v, 64'hC0, 1'b0);
    @(posedge clock_i); #2;
    reset_i = 1'b1;
    #1;
    checkOutput("discard_reset_enable", {63'd0, enable_o}, 64'd0);
    checkOutput("discard_reset_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("discard_reset_taken", {63'd0, taken_o}, 64'd0);
    checkOutput("discard_reset_redirect", redirectAddr_o, 64'd0);
    checkOutput("discard_reset_id", instMajId_o, 64'd0);
    checkOutput("discard_reset_ctr", ctr_o, 64'd0);
    checkOutput("discard_reset_lr", lr_o, 64'd0);
    #1;
    reset_i   = 1'b0;
    crValid_i = 1'b1;
    crBits_i  = v.cr;
    repeat (3) begin
      @(negedge clock_i);
      checkOutput("discard_enable", {63'd0, enable_o}, 64'd0);
      checkOutput("discard_busy", {63'd0, busy_o}, 64'd0);
    end
    checkOutput("discard_ctr", ctr_o, 64'd0);
    checkOutput("discard_lr", lr_o, 64'd0);

    @(posedge clock_i); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
